frame_buffer_pp: RTL and testbench
==================================

# frame_buffer_pp

Single-clock, parametrised, double-buffered (ping-pong) frame store between the OV7670 capture path and the VGA pixel fetch. It generates write addresses internally from a pixel stream and swaps banks only on a display frame boundary, so the display never shows a partially written frame. A single-bank mode covers the plain frame buffer use case. The block also flags overlong and short frames.

## Interface
- DATA_W, 16, pixel width (RGB565 default)
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- DOUBLE_BUF, 1, 1 = two banks with ping-pong swap; 0 = one bank with no swap
- ADDR_W, $clog2(H_RES*V_RES), read address width (derived; do not override)

Ports:
- clk  in  1  single clock for both write and read sides
- reset_n  in  1  synchronous, active-low reset
- wr_sof  in  1  one-cycle pulse that starts a camera frame
- wr_valid  in  1  wr_data valid this cycle
- wr_data  in  DATA_W  pixel in raster order
- rd_sof  in  1  one-cycle pulse at the start of the VGA frame; the swap point
- oe  in  1  read enable
- rAddr  in  ADDR_W  read pixel index, y*H_RES+x
- rData  out  DATA_W  registered read data
- rd_valid  out  1  rData qualifies the request from the previous cycle
- frame_ready  out  1  a completed frame is waiting for a swap
- frame_cnt  out  8  count of completed frames, wraps 255->0
- err_overflow  out  1  sticky; set when wr_valid arrives outside an active frame
- err_short  out  1  sticky; set when wr_sof arrives mid-frame

## Operation
- Storage is NB = DOUBLE_BUF ? 2 : 1 banks of H_RES*V_RES words.
- Memory contents are not cleared by reset.
- Registers: wr_bank, disp_bank, wr_addr, and write state IDLE/ACTIVE/DONE.
- Write FSM:
  - IDLE or DONE, wr_sof: wr_addr<=0, go to ACTIVE.
  - ACTIVE, wr_valid: write mem[wr_bank][wr_addr], then wr_addr++.
  - Final write at wr_addr = H_RES*V_RES-1: go to DONE, frame_ready<=1, frame_cnt++.
  - ACTIVE, wr_sof: abort the frame, err_short<=1, wr_addr<=0, stay ACTIVE in the same bank. No swap and no frame_cnt increment.
  - IDLE or DONE, wr_valid without a new wr_sof: no write, err_overflow<=1.
- Swap, DOUBLE_BUF=1:
  - rd_sof with frame_ready=1: disp_bank<=wr_bank, wr_bank<=old disp_bank, frame_ready<=0.
  - rd_sof with frame_ready=0: no change. The display repeats its current bank.
- Dropped frame, DOUBLE_BUF=1: wr_sof while frame_ready=1 and no swap that cycle clears frame_ready. The writer overwrites the same wr_bank and the completed frame is dropped.
- Simultaneous rd_sof and wr_sof, frame_ready=1: the swap happens first. The new frame writes into the freed bank, which is the pre-swap disp_bank.
- DOUBLE_BUF=0:
  - wr_bank = disp_bank = 0 always.
  - frame_ready pulses high for one cycle on completion.
  - rd_sof is ignored. Tearing is accepted in this mode.
- Read, all modes:
  - oe=1 and rAddr < H_RES*V_RES: rData<=mem[disp_bank][rAddr].
  - oe=1 and rAddr out of range: rData<=0.
  - oe=0: rData<=0.
  - rd_valid<=oe.
- Address arithmetic: wr_addr is ADDR_W wide and never wraps. Completion is detected by compare, not by overflow.

## Timing
- All outputs reset to:
  - rData=0, rd_valid=0
  - frame_ready=0, frame_cnt=0
  - err_overflow=0, err_short=0
- Internal reset state: state=IDLE, wr_addr=0, disp_bank=0, wr_bank=(DOUBLE_BUF?1:0).
- Read latency is exactly 1 cycle from oe/rAddr to rData/rd_valid, with no back-pressure.
- Write pixel accepted in cycle N is readable at cycle N+1 only when it lands in disp_bank, which happens in DOUBLE_BUF=0 only.
- frame_ready rises the cycle after the final write. A swap takes effect on the first rd_sof edge at or after that cycle. An rd_sof in the same cycle as the final write does not swap.
- Bank select for a read is sampled on the same edge as rAddr. A read coincident with the swapping rd_sof returns old-bank data.
- Reset mid-frame: the write is abandoned, the FSM returns to IDLE and the flags clear. Memory keeps partial data.
- Error flags clear only on reset.

## Test plan
- Reset, then one full frame (76800 pixels, data = index[15:0]), then rd_sof, then reads at addresses 0, 319, 76799 -> rData = 0x0000, 0x013F, 0x2BFF one cycle later; frame_ready 1->0 on rd_sof; frame_cnt=1.
- Double buffering: frame A fully displayed, frame B written with no rd_sof -> reads still return A. After rd_sof, reads return B; disp_bank and wr_bank toggle.
- Abort: wr_sof after 1000 pixels, then a full frame of pattern 0xAAAA -> err_short=1, frame_cnt=1, every pixel after the swap reads 0xAAAA.
- Overflow: 76801 valid pixels in one frame -> the last pixel is not written, err_overflow=1, pixel 0 unchanged.
- Reads with oe=0 or rAddr=76800 -> rData=0; rd_valid tracks oe with a 1-cycle delay.
- Simultaneous rd_sof and wr_sof while frame_ready=1 -> swap occurs and the next frame writes the old display bank. Then, with DOUBLE_BUF=0, a write at cycle N is read back at N+1.

Source files
------------

// File: rtl/frame_buffer_pp.sv
// ---------------------------------------------------------------------------
// frame_buffer_pp
//
// Double-buffered (ping-pong) frame store between a camera pixel stream and a
// display pixel fetch, all on one clock. Incoming pixels are written in raster
// order at internally generated addresses. The write and display banks swap
// only on a display start-of-frame that follows a completed frame, so the
// display never shows a half-written frame. With DOUBLE_BUF=0 a single bank
// is used and reads may tear.
//
// Ports:
//   clk           single clock for both write and read sides
//   reset_n       synchronous, active-low reset
//   wr_sof        one-cycle pulse starting a camera frame
//   wr_valid      wr_data is valid this cycle
//   wr_data       pixel, raster order
//   rd_sof        one-cycle pulse at display start-of-frame (swap point)
//   oe            read enable
//   rAddr         read pixel index, y*H_RES+x
//   rData         registered read data (0 when not enabled or out of range)
//   rd_valid      rData qualifies the request from the previous cycle
//   frame_ready   a completed frame is waiting for a swap (one-cycle pulse
//                 on completion when DOUBLE_BUF=0)
//   frame_cnt     completed frame count, wraps 255->0
//   err_overflow  sticky: pixel arrived outside an active frame
//   err_short     sticky: new frame started before the previous one finished
// ---------------------------------------------------------------------------
module frame_buffer_pp #(
    parameter int DATA_W     = 16,
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int DOUBLE_BUF = 1,
    parameter int ADDR_W     = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_sof,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_sof,
    input  logic              oe,
    input  logic [ADDR_W-1:0] rAddr,
    output logic [DATA_W-1:0] rData,
    output logic              rd_valid,
    output logic              frame_ready,
    output logic [7:0]        frame_cnt,
    output logic              err_overflow,
    output logic              err_short
);

    localparam int NPIX = H_RES * V_RES;
    localparam int NB   = (DOUBLE_BUF != 0) ? 2 : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    // One extra bit so the frame size itself is representable for the
    // out-of-range read compare.
    localparam logic [ADDR_W:0]   NPIX_EXT  = (ADDR_W + 1)'(NPIX);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bank;
    logic              disp_bank;

    logic              start;       // new frame begins from IDLE/DONE
    logic              abort;       // wr_sof arrived mid-frame
    logic              do_write;    // pixel written this cycle
    logic              frame_done;  // this write completes the frame
    logic              overflow;    // pixel outside an active frame
    logic              swap;

    logic [DATA_W-1:0] mem [NB][NPIX];

    assign swap = (DOUBLE_BUF != 0) && rd_sof && frame_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal gets a default before the case; without it a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        do_write   = 1'b0;
        frame_done = 1'b0;
        overflow   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (wr_sof) begin
                    start      = 1'b1;
                    state_next = ACTIVE;
                end else if (wr_valid) begin
                    overflow = 1'b1;
                end
            end
            ACTIVE: begin
                // A restart beats a pixel in the same cycle.
                if (wr_sof) begin
                    abort = 1'b1;
                end else if (wr_valid) begin
                    do_write = 1'b1;
                    if (wr_addr == LAST_ADDR) begin
                        frame_done = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ----------------------------------------------- addresses, banks, flags
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block samples the pre-edge values (the bank swap relies on it).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_addr      <= '0;
            wr_bank      <= 1'(DOUBLE_BUF != 0);
            disp_bank    <= 1'b0;
            frame_ready  <= 1'b0;
            frame_cnt    <= 8'd0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            if (start || abort)
                wr_addr <= '0;
            else if (do_write)
                wr_addr <= wr_addr + ADDR_W'(1);

            if (frame_done) frame_cnt    <= frame_cnt + 8'd1;
            if (abort)      err_short    <= 1'b1;
            if (overflow)   err_overflow <= 1'b1;

            if (DOUBLE_BUF != 0) begin
                if (swap) begin
                    disp_bank <= wr_bank;
                    wr_bank   <= disp_bank;
                end
                // Starting a new frame without a swap drops the waiting one;
                // the writer reuses the same bank.
                if (frame_done)
                    frame_ready <= 1'b1;
                else if (swap || (start && frame_ready))
                    frame_ready <= 1'b0;
            end else begin
                wr_bank     <= 1'b0;
                disp_bank   <= 1'b0;
                frame_ready <= frame_done;
            end
        end
    end

    // ---------------------------------------------------------------- memory
    // NOTE: the pixel array has no reset so it maps onto block RAM; contents
    // survive reset by design.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_bank][wr_addr] <= wr_data;
    end

    // disp_bank is the pre-swap value here, so a read issued with the
    // swapping rd_sof still returns the old bank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rData    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= oe;
            if (oe && ({1'b0, rAddr} < NPIX_EXT))
                rData <= mem[disp_bank][rAddr];
            else
                rData <= '0;
        end
    end

endmodule

// File: tb/tb_frame_buffer_pp.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_pp
//
// Drives one double-buffered and one single-bank instance from a shared
// stimulus on a reduced 20x6 frame. A behavioural model (pixel counter per
// frame, bank pair, plain arrays for both banks) predicts every output each
// cycle; directed literal checks pin the model at the key moments.
// ---------------------------------------------------------------------------
module tb_frame_buffer_pp;

    localparam int DW   = 16;
    localparam int H    = 20;
    localparam int V    = 6;
    localparam int NPIX = H * V;
    localparam int AW   = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_sof;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rd_sof;
    logic          oe;
    logic [AW-1:0] raddr;

    // index 0: DOUBLE_BUF=1, index 1: DOUBLE_BUF=0
    logic [DW-1:0] rdata_o  [2];
    logic          rvalid_o [2];
    logic          ready_o  [2];
    logic [7:0]    fcnt_o   [2];
    logic          eovf_o   [2];
    logic          eshort_o [2];

    always #5 clk = ~clk;

    frame_buffer_pp #(.DATA_W(DW), .H_RES(H), .V_RES(V), .DOUBLE_BUF(1)) dut_db (
        .clk(clk), .reset_n(reset_n), .wr_sof(wr_sof), .wr_valid(wr_valid),
        .wr_data(wr_data), .rd_sof(rd_sof), .oe(oe), .rAddr(raddr),
        .rData(rdata_o[0]), .rd_valid(rvalid_o[0]), .frame_ready(ready_o[0]),
        .frame_cnt(fcnt_o[0]), .err_overflow(eovf_o[0]), .err_short(eshort_o[0])
    );

    frame_buffer_pp #(.DATA_W(DW), .H_RES(H), .V_RES(V), .DOUBLE_BUF(0)) dut_sb (
        .clk(clk), .reset_n(reset_n), .wr_sof(wr_sof), .wr_valid(wr_valid),
        .wr_data(wr_data), .rd_sof(rd_sof), .oe(oe), .rAddr(raddr),
        .rData(rdata_o[1]), .rd_valid(rvalid_o[1]), .frame_ready(ready_o[1]),
        .frame_cnt(fcnt_o[1]), .err_overflow(eovf_o[1]), .err_short(eshort_o[1])
    );

    // ------------------------------------------------------------ scoring
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------ model
    bit          m_active [2];
    int          m_cnt    [2];
    bit          m_wb     [2];
    bit          m_dispb  [2];
    bit          m_ready  [2];
    int          m_fcnt   [2];
    bit          m_ovf    [2];
    bit          m_short  [2];
    logic [15:0] m_rdata  [2];
    bit          m_rknown [2];
    bit          m_rvalid [2];
    logic [15:0] m_mem    [2][2][NPIX];
    bit          m_kn     [2][2][NPIX];

    function automatic void model_reset(input int m);
        m_active[m] = 1'b0;
        m_cnt[m]    = 0;
        m_wb[m]     = (m == 0);
        m_dispb[m]  = 1'b0;
        m_ready[m]  = 1'b0;
        m_fcnt[m]   = 0;
        m_ovf[m]    = 1'b0;
        m_short[m]  = 1'b0;
        m_rdata[m]  = 16'h0;
        m_rknown[m] = 1'b1;
        m_rvalid[m] = 1'b0;
    endfunction

    function automatic void model_step(input int m);
        bit dbl;
        bit old_ready;
        bit swp;
        bit tmp;
        bit complete;
        dbl = (m == 0);
        // read sees the bank and contents as they were before this edge
        if (oe && int'(raddr) < NPIX) begin
            m_rdata[m]  = m_mem[m][m_dispb[m]][raddr];
            m_rknown[m] = m_kn[m][m_dispb[m]][raddr];
        end else begin
            m_rdata[m]  = 16'h0;
            m_rknown[m] = 1'b1;
        end
        m_rvalid[m] = oe;

        old_ready = m_ready[m];
        swp       = dbl && rd_sof && old_ready;
        complete  = 1'b0;
        if (swp) begin
            tmp         = m_dispb[m];
            m_dispb[m]  = m_wb[m];
            m_wb[m]     = tmp;
            m_ready[m]  = 1'b0;
        end
        if (!m_active[m]) begin
            if (wr_sof) begin
                m_active[m] = 1'b1;
                m_cnt[m]    = 0;
                if (dbl && old_ready && !swp) m_ready[m] = 1'b0;
            end else if (wr_valid) begin
                m_ovf[m] = 1'b1;
            end
        end else if (wr_sof) begin
            m_short[m] = 1'b1;
            m_cnt[m]   = 0;
        end else if (wr_valid) begin
            m_mem[m][m_wb[m]][m_cnt[m]] = wr_data;
            m_kn[m][m_wb[m]][m_cnt[m]]  = 1'b1;
            m_cnt[m]++;
            if (m_cnt[m] == NPIX) begin
                m_active[m] = 1'b0;
                m_fcnt[m]   = (m_fcnt[m] + 1) % 256;
                complete    = 1'b1;
            end
        end
        if (dbl) begin
            if (complete) m_ready[m] = 1'b1;
        end else begin
            m_ready[m] = complete;
        end
    endfunction

    initial begin
        model_reset(0);
        model_reset(1);
    end

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) model_reset(m);
            else          model_step(m);
        end
    end

    // ------------------------------------------------------------ compare
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                check($sformatf("m%0d rd_valid", m), rvalid_o[m], m_rvalid[m]);
                check($sformatf("m%0d frame_ready", m), ready_o[m], m_ready[m]);
                check($sformatf("m%0d frame_cnt", m), fcnt_o[m], m_fcnt[m]);
                check($sformatf("m%0d err_overflow", m), eovf_o[m], m_ovf[m]);
                check($sformatf("m%0d err_short", m), eshort_o[m], m_short[m]);
                if (m_rknown[m])
                    check($sformatf("m%0d rData", m), rdata_o[m], m_rdata[m]);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step(input bit sof, input bit valid, input logic [15:0] data,
                        input bit rsof, input bit o, input int a);
        @(negedge clk);
        wr_sof   = sof;
        wr_valid = valid;
        wr_data  = data;
        rd_sof   = rsof;
        oe       = o;
        raddr    = AW'(a);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0);
    endtask

    task automatic rand_idle();
        step(1'b0, 1'b0, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)),
             $urandom_range(0, (1 << AW) - 1));
    endtask

    function automatic logic [15:0] pat(input int kind, input int i);
        logic [15:0] v;
        v = 16'(i);
        case (kind)
            0:       pat = v;
            1:       pat = v ^ 16'h5A5A;
            2:       pat = 16'hAAAA;
            3:       pat = v + 16'h0100;
            default: pat = ~v;
        endcase
    endfunction

    // wr_sof (optionally with rd_sof), then n pixels with random gaps and
    // random background reads.
    task automatic write_frame(input int n, input int kind, input bit with_rsof);
        step(1'b1, 1'b0, 16'h0, with_rsof, 1'b0, 0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) rand_idle();
            step(1'b0, 1'b1, pat(kind, i), 1'b0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, (1 << AW) - 1));
        end
    endtask

    // issue one read, then check both instances' result the next cycle
    task automatic read_lit(input string name, input int a,
                            input logic [15:0] exp_db, input logic [15:0] exp_sb);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, a);
        idle();
        check({name, " db"}, rdata_o[0], exp_db);
        check({name, " sb"}, rdata_o[1], exp_sb);
        check({name, " rd_valid"}, rvalid_o[0], 1);
    endtask

    task automatic swap_pulse();
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 0);
        idle();
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_sof   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_sof   = 1'b0;
        oe       = 1'b0;
        raddr    = '0;
        repeat (3) @(negedge clk);
        chk_en  = 1'b1;
        // reset state
        for (int m = 0; m < 2; m++) begin
            check("reset rData", rdata_o[m], 0);
            check("reset rd_valid", rvalid_o[m], 0);
            check("reset frame_ready", ready_o[m], 0);
            check("reset frame_cnt", fcnt_o[m], 0);
            check("reset err_overflow", eovf_o[m], 0);
            check("reset err_short", eshort_o[m], 0);
        end
        reset_n = 1'b1;
        idle();

        // frame A = index
        write_frame(NPIX, 0, 1'b0);
        idle();
        check("A done frame_ready", ready_o[0], 1);
        check("A done frame_cnt", fcnt_o[0], 1);
        swap_pulse();
        check("A swapped frame_ready", ready_o[0], 0);
        read_lit("A px0",   0,        16'h0000, 16'h0000);
        read_lit("A px19",  H - 1,    16'h0013, 16'h0013);
        read_lit("A last",  NPIX - 1, 16'h0077, 16'h0077);
        read_lit("oor addr", NPIX,    16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 5);
        idle();
        check("oe=0 rData", rdata_o[0], 0);
        check("oe=0 rd_valid", rvalid_o[0], 0);

        // frame B without swap: display keeps A; single bank reads B at N+1
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        for (int i = 0; i < NPIX; i++) begin
            step(1'b0, 1'b1, pat(1, i), 1'b0, 1'b0, 0);
            if (i == 7) begin
                step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 7);
                idle();
                check("sb write->read N+1", rdata_o[1], 16'h5A5D);
                check("db still shows A", rdata_o[0], 16'h0007);
            end
        end
        idle();
        read_lit("B unswapped", 5, 16'h0005, 16'h5A5F);
        swap_pulse();
        read_lit("B swapped", 5, 16'h5A5F, 16'h5A5F);

        // aborted frame, then full 0xAAAA frame
        write_frame(30, 0, 1'b0);
        write_frame(NPIX, 2, 1'b0);
        idle();
        check("abort err_short", eshort_o[0], 1);
        check("abort frame_cnt", fcnt_o[0], 3);
        swap_pulse();
        for (int k = 0; k < 12; k++) begin
            int a;
            a = $urandom_range(0, NPIX - 1);
            read_lit("abort AAAA", a, 16'hAAAA, 16'hAAAA);
        end

        // overflow: one pixel too many
        write_frame(NPIX + 1, 3, 1'b0);
        idle();
        check("overflow err_overflow", eovf_o[0], 1);
        check("overflow frame_cnt", fcnt_o[0], 4);
        // simultaneous rd_sof + wr_sof with frame_ready: swap first, new frame
        // lands in the freed bank
        write_frame(NPIX, 4, 1'b1);
        idle();
        read_lit("sim px0 old frame", 0, 16'h0100, 16'hFFFF);
        swap_pulse();
        read_lit("sim px0 new frame", 0, 16'hFFFF, 16'hFFFF);

        // random traffic
        for (int c = 0; c < 2500; c++) begin
            bit s;
            s = ($urandom_range(0, 299) == 0);
            step(s, !s && ($urandom_range(0, 2) != 0), 16'($urandom),
                 ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(0, (1 << AW) - 1));
        end

        // reset mid-frame clears flags, memory keeps data
        write_frame(10, 0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        reset_n = 1'b0;
        idle();
        idle();
        reset_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            check("midreset frame_cnt", fcnt_o[m], 0);
            check("midreset err_short", eshort_o[m], 0);
            check("midreset err_overflow", eovf_o[m], 0);
            check("midreset frame_ready", ready_o[m], 0);
        end
        write_frame(NPIX, 0, 1'b0);
        idle();
        swap_pulse();
        read_lit("post-reset px19", H - 1, 16'h0013, 16'h0013);

        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
